// File: rtl/haar_pkg.sv
// Shared definitions for the streaming forward Haar stage.
//   haar_state_t : pairing FSM state (EVEN: nothing held, ODD: sample a held,
//                  PAD: odd-length frame ended on a, padded pair pending)
//   HAAR_MAX_W   : widest sample width the shared average helper supports
//   haar_avg()   : (a + b + round) >> 1 evaluated with one guard bit, so it never overflows
package haar_pkg;

    typedef enum logic [1:0] {
        ST_EVEN = 2'd0,
        ST_ODD  = 2'd1,
        ST_PAD  = 2'd2
    } haar_state_t;

    localparam int unsigned HAAR_MAX_W = 64;

    function automatic logic [HAAR_MAX_W-1:0] haar_avg(
        input logic [HAAR_MAX_W-1:0] a,
        input logic [HAAR_MAX_W-1:0] b,
        input logic                  round
    );
        return HAAR_MAX_W'(({1'b0, a} + {1'b0, b} + (HAAR_MAX_W + 1)'(round)) >> 1);
    endfunction

endpackage

// File: rtl/haar_pair_core.sv
// Combinational Haar butterfly for one sample pair.
//   i_a, i_b : unsigned samples (a = even, b = odd)
//   o_avg    : (a + b + ROUND) >> 1, unsigned, DATA_W bits
//   o_diff   : a - b, two's complement, DATA_W+1 bits (full range, no saturation)
module haar_pair_core
    import haar_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROUND  = 0
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_avg,
    output logic [DATA_W:0]   o_diff
);

    logic [HAAR_MAX_W-1:0]      w_avg_wide;
    logic [HAAR_MAX_W-1:DATA_W] w_unused_avg_hi;

    // The average of two DATA_W-bit values always fits in DATA_W bits, so the
    // upper bits of the wide helper result are always zero.
    assign w_avg_wide      = haar_avg(HAAR_MAX_W'(i_a), HAAR_MAX_W'(i_b), ROUND != 0);
    assign o_avg           = w_avg_wide[DATA_W-1:0];
    assign w_unused_avg_hi = w_avg_wide[HAAR_MAX_W-1:DATA_W];

    assign o_diff = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/haar_fwd_stream.sv
// Streaming 1-D forward Haar stage. Pairs consecutive samples of a frame and
// emits (avg, diff) per pair through a single output register stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   clr        : synchronous flush (held sample, output word, pair index)
//   s_valid/s_ready/s_data/s_last : sample input stream
//   m_valid/m_ready               : output pair handshake
//   m_avg, m_diff                 : approximation / detail coefficients
//   m_idx                         : pair index within the frame
//   m_last                        : final pair of the frame
//   m_pad                         : pair padded from an odd-length frame (b = a)
module haar_fwd_stream
    import haar_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROUND  = 0,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_avg,
    output logic [DATA_W:0]   m_diff,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic              m_pad
);

    haar_state_t       r_state;
    haar_state_t       w_next_state;
    logic [DATA_W-1:0] r_held;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_avg;
    logic [DATA_W:0]   r_m_diff;
    logic [IDX_W-1:0]  r_m_idx;
    logic              r_m_last;
    logic              r_m_pad;

    logic              w_out_free;
    logic              w_store_a;
    logic              w_load;
    logic [DATA_W-1:0] w_b;
    logic              w_load_last;
    logic              w_load_pad;
    logic [DATA_W-1:0] w_avg;
    logic [DATA_W:0]   w_diff;

    assign w_out_free = !r_m_valid || m_ready;

    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        w_store_a    = 1'b0;
        w_load       = 1'b0;
        w_b          = s_data;
        w_load_last  = 1'b0;
        w_load_pad   = 1'b0;
        unique case (r_state)
            ST_EVEN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_store_a    = 1'b1;
                    w_next_state = s_last ? ST_PAD : ST_ODD;
                end
            end
            ST_ODD: begin
                // Only state where s_ready looks at m_ready (via out_free).
                s_ready = w_out_free;
                if (s_valid && w_out_free) begin
                    w_load       = 1'b1;
                    w_b          = s_data;
                    w_load_last  = s_last;
                    w_next_state = ST_EVEN;
                end
            end
            ST_PAD: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_b          = r_held;
                    w_load_last  = 1'b1;
                    w_load_pad   = 1'b1;
                    w_next_state = ST_EVEN;
                end
            end
            default: begin
                w_next_state = ST_EVEN;
            end
        endcase
    end

    haar_pair_core #(
        .DATA_W (DATA_W),
        .ROUND  (ROUND)
    ) u_core (
        .i_a    (r_held),
        .i_b    (w_b),
        .o_avg  (w_avg),
        .o_diff (w_diff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EVEN;
            r_held    <= '0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_avg   <= '0;
            r_m_diff  <= '0;
            r_m_idx   <= '0;
            r_m_last  <= 1'b0;
            r_m_pad   <= 1'b0;
        end else if (clr) begin
            // Flush wins over any handshake on the same edge.
            r_state   <= ST_EVEN;
            r_held    <= '0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_avg   <= '0;
            r_m_diff  <= '0;
            r_m_idx   <= '0;
            r_m_last  <= 1'b0;
            r_m_pad   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_store_a) begin
                r_held <= s_data;
            end
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_avg   <= w_avg;
                r_m_diff  <= w_diff;
                r_m_idx   <= r_cnt;
                r_m_last  <= w_load_last;
                r_m_pad   <= w_load_pad;
                r_cnt     <= w_load_last ? '0 : r_cnt + IDX_W'(1);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_avg   = r_m_avg;
    assign m_diff  = r_m_diff;
    assign m_idx   = r_m_idx;
    assign m_last  = r_m_last;
    assign m_pad   = r_m_pad;

endmodule

// File: tb/tb_haar_fwd_stream.sv
// Self-checking bench for haar_fwd_stream: one truncating and one rounding
// instance share the stimulus; a frame-level pairing model predicts every word.
module tb_haar_fwd_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b1;

    logic       s_ready0, m_valid0, m_last0, m_pad0;
    logic [7:0] m_avg0, m_idx0;
    logic [8:0] m_diff0;
    logic       s_ready1, m_valid1, m_last1, m_pad1;
    logic [7:0] m_avg1, m_idx1;
    logic [8:0] m_diff1;

    always #5 clk = ~clk;

    haar_fwd_stream #(.DATA_W(8), .ROUND(0), .IDX_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid0), .m_ready(m_ready), .m_avg(m_avg0), .m_diff(m_diff0),
        .m_idx(m_idx0), .m_last(m_last0), .m_pad(m_pad0)
    );

    haar_fwd_stream #(.DATA_W(8), .ROUND(1), .IDX_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid1), .m_ready(m_ready), .m_avg(m_avg1), .m_diff(m_diff1),
        .m_idx(m_idx1), .m_last(m_last1), .m_pad(m_pad1)
    );

    typedef struct {int a; int b; int idx; bit last; bit pad;} exp_t;
    typedef struct {int avg0; int avg1; int diff; int idx; int last; int pad;} obs_t;

    exp_t q0[$];
    exp_t q1[$];
    obs_t obs[$];
    int   total = 0;
    int   bad = 0;
    int   mdl_have_a = 0;
    int   mdl_a = 0;
    int   mdl_idx = 0;
    bit   pad_chk = 1'b0;
    int   mr_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int e_avg(input exp_t e, input int rnd);
        return (e.a + e.b + rnd) / 2;
    endfunction

    function automatic int e_diff(input exp_t e);
        return (e.a - e.b) & 32'h1FF;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        mdl_have_a = 0;
        mdl_idx = 0;
        pad_chk = 1'b0;
    endtask

    // Compare / model process: everything sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst m_valid", m_valid0, 0);
            chk("rst m_avg", m_avg0, 0);
            chk("rst m_diff", m_diff0, 0);
            chk("rst m_idx", m_idx0, 0);
            chk("rst m_last", m_last0, 0);
            chk("rst m_pad", m_pad0, 0);
            chk("rst r1 m_valid", m_valid1, 0);
            chk("rst r1 m_avg", m_avg1, 0);
            model_clear();
        end else if (clr) begin
            model_clear();
        end else begin
            if (m_valid0) begin
                if (q0.size() == 0) begin
                    chk("r0 spurious m_valid", 1, 0);
                end else begin
                    e = q0[0];
                    chk("r0 avg", m_avg0, e_avg(e, 0));
                    chk("r0 diff", m_diff0, e_diff(e));
                    chk("r0 idx", m_idx0, e.idx);
                    chk("r0 last", m_last0, e.last);
                    chk("r0 pad", m_pad0, e.pad);
                    if (m_ready) begin
                        void'(q0.pop_front());
                        obs.push_back('{int'(m_avg0), int'(m_avg1), int'(m_diff0),
                                        int'(m_idx0), int'(m_last0), int'(m_pad0)});
                    end
                end
            end
            if (m_valid1) begin
                if (q1.size() == 0) begin
                    chk("r1 spurious m_valid", 1, 0);
                end else begin
                    e = q1[0];
                    chk("r1 avg", m_avg1, e_avg(e, 1));
                    chk("r1 diff", m_diff1, e_diff(e));
                    chk("r1 idx", m_idx1, e.idx);
                    chk("r1 last", m_last1, e.last);
                    chk("r1 pad", m_pad1, e.pad);
                    if (m_ready) void'(q1.pop_front());
                end
            end
            if (pad_chk) begin
                chk("s_ready in PAD", s_ready0, 0);
                pad_chk = 1'b0;
            end
            if (s_valid && s_ready0) begin
                if (mdl_have_a != 0) begin
                    e = '{mdl_a, int'(s_data), mdl_idx, s_last, 1'b0};
                    q0.push_back(e);
                    q1.push_back(e);
                    mdl_have_a = 0;
                    mdl_idx = s_last ? 0 : (mdl_idx + 1) % 256;
                end else if (s_last) begin
                    e = '{int'(s_data), int'(s_data), mdl_idx, 1'b1, 1'b1};
                    q0.push_back(e);
                    q1.push_back(e);
                    mdl_idx = 0;
                    pad_chk = 1'b1;
                end else begin
                    mdl_have_a = 1;
                    mdl_a = int'(s_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input int d, input bit l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data = 8'(d);
        s_last = l;
        @(negedge clk);
        while (!s_ready0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready0) chk("send timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || m_valid0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || m_valid0) chk("drain timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input int i, input int avg0, input int avg1,
                       input int diff, input int idx, input int last, input int pad);
        if (i >= obs.size()) begin
            chk({n, " missing"}, 0, 1);
            return;
        end
        chk({n, " avg"}, obs[i].avg0, avg0);
        chk({n, " avg round"}, obs[i].avg1, avg1);
        chk({n, " diff"}, obs[i].diff, diff);
        chk({n, " idx"}, obs[i].idx, idx);
        chk({n, " last"}, obs[i].last, last);
        chk({n, " pad"}, obs[i].pad, pad);
    endtask

    task automatic idx_at(input string n, input int i, input int idx);
        if (i >= obs.size()) chk({n, " missing"}, 0, 1);
        else chk(n, obs[i].idx, idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready after reset", s_ready0, 1);
        @(posedge clk);
        #1;

        // 1: even frame, truncating average
        obs.delete();
        send(200, 0);
        send(101, 1);
        drain();
        chk("t1 word count", obs.size(), 1);
        lit("t1", 0, 150, 151, 'h063, 0, 1, 0);

        // 2: rounding vs truncation at the extreme spread
        obs.delete();
        send(0, 0);
        send(255, 1);
        drain();
        chk("t2 word count", obs.size(), 1);
        lit("t2", 0, 127, 128, 'h101, 0, 1, 0);

        // 3: odd-length frame, padded final pair
        obs.delete();
        send(10, 0);
        send(20, 0);
        send(30, 1);
        drain();
        chk("t3 word count", obs.size(), 2);
        lit("t3 w0", 0, 15, 15, 'h1F6, 0, 0, 0);
        lit("t3 w1", 1, 30, 30, 'h000, 1, 1, 1);

        // 4: backpressure with m_ready toggling each cycle
        obs.delete();
        mr_mode = 1;
        for (int i = 1; i <= 8; i++) send(i, i == 8);
        drain();
        mr_mode = 0;
        chk("t4 word count", obs.size(), 4);
        for (int k = 0; k < 4; k++)
            lit($sformatf("t4 w%0d", k), k, 2 * k + 1, 2 * k + 2, 'h1FF, k, (k == 3) ? 1 : 0, 0);

        // 5: reset in the middle of a frame
        obs.delete();
        send(50, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(60, 0);
        send(70, 1);
        drain();
        chk("t5 word count", obs.size(), 1);
        lit("t5", 0, 65, 65, 'h1F6, 0, 1, 0);

        // 6: pair index wrap over 512 pairs, then flush
        obs.delete();
        for (int i = 0; i < 1024; i++) send((i * 37) % 256, 0);
        drain();
        chk("t6 word count", obs.size(), 512);
        idx_at("t6 idx 255", 255, 255);
        idx_at("t6 idx wrap", 256, 0);
        idx_at("t6 idx 511", 511, 255);
        for (int i = 0; i < 6; i++) send(i + 1, 0);
        drain();
        mr_mode = 2;
        m_ready = 1'b0;
        send(11, 0);
        send(12, 0);
        @(negedge clk);
        chk("t6 held m_valid", m_valid0, 1);
        chk("t6 held m_idx", m_idx0, 3);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t6 clr m_valid", m_valid0, 0);
        chk("t6 clr m_idx", m_idx0, 0);
        chk("t6 clr r1 m_valid", m_valid1, 0);
        @(posedge clk);
        #1;
        mr_mode = 0;
        m_ready = 1'b1;
        obs.delete();
        send(7, 0);
        send(9, 1);
        drain();
        chk("t6 post-clr count", obs.size(), 1);
        lit("t6 post-clr", 0, 8, 8, 'h1FE, 0, 1, 0);

        chk("final queue empty", q0.size(), 0);
        chk("final m_valid", m_valid0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
